// File: rtl/rx_lbuf_pkg.sv
// Shared definitions for the receive large-buffer scheduler: FSM encoding,
// buffer identifiers and default widths.
package rx_lbuf_pkg;

   localparam int unsigned DEF_ADDR_W = 64;
   localparam int unsigned DEF_CNT_W  = 32;

   localparam logic LBUF_ID_1 = 1'b0;
   localparam logic LBUF_ID_2 = 1'b1;

   typedef enum logic [3:0] {
      StWait  = 4'b0001,
      StOffer = 4'b0010,
      StBusy  = 4'b0100,
      StRel   = 4'b1000
   } sched_state_e;

endpackage

// File: rtl/rx_lbuf_slot.sv
// Per-buffer arming tracker: a buffer is eligible only once the host has
// dropped its enable since the last release.
module rx_lbuf_slot (
   input  logic clk,
   input  logic rst_n,
   input  logic en_i,
   input  logic rel_i,
   output logic elig_o
);

   logic armed_q, armed_d;

   // A low enable re-arms even in the release cycle: the host has already let go.
   always_comb begin
      armed_d = armed_q;
      if (!en_i) begin
         armed_d = 1'b1;
      end else if (rel_i) begin
         armed_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         armed_q <= 1'b0;
      end else begin
         armed_q <= armed_d;
      end
   end

   assign elig_o = en_i & armed_q;

endmodule

// File: rtl/rx_lbuf_sched.sv
// Ping-pong scheduler handing lbuf1/lbuf2 to the rx DMA write engine in
// strict alternation, with a done pulse back to the host decoder.
module rx_lbuf_sched
   import rx_lbuf_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W,
   parameter int unsigned CNT_W  = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] lbuf1_addr,
   input  logic              lbuf1_en,
   output logic              lbuf1_dn,
   input  logic [ADDR_W-1:0] lbuf2_addr,
   input  logic              lbuf2_en,
   output logic              lbuf2_dn,
   output logic              eng_vld,
   output logic [ADDR_W-1:0] eng_addr,
   output logic              eng_id,
   input  logic              eng_ack,
   input  logic              eng_dn,
   output logic              busy,
   output logic [CNT_W-1:0]  served_cnt
);

   sched_state_e      state_q, state_d;
   logic              cur_q, cur_d;
   logic              id_q, id_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic elig1, elig2, rel1, rel2, cur_elig;

   assign rel1 = (state_q == StRel) && (cur_q == LBUF_ID_1);
   assign rel2 = (state_q == StRel) && (cur_q == LBUF_ID_2);

   rx_lbuf_slot u_slot1 (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (lbuf1_en),
      .rel_i  (rel1),
      .elig_o (elig1)
   );

   rx_lbuf_slot u_slot2 (
      .clk    (clk),
      .rst_n  (rst_n),
      .en_i   (lbuf2_en),
      .rel_i  (rel2),
      .elig_o (elig2)
   );

   // Only the current buffer is ever looked at; the other one waits its turn.
   assign cur_elig = (cur_q == LBUF_ID_2) ? elig2 : elig1;

   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      id_d    = id_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         StWait: begin
            if (cur_elig) begin
               addr_d  = (cur_q == LBUF_ID_2) ? lbuf2_addr : lbuf1_addr;
               id_d    = cur_q;
               state_d = StOffer;
            end
         end
         StOffer: begin
            if (eng_ack) begin
               state_d = eng_dn ? StRel : StBusy;
            end
         end
         StBusy: begin
            if (eng_dn) begin
               state_d = StRel;
            end
         end
         StRel: begin
            cnt_d   = cnt_q + CNT_W'(1);
            cur_d   = ~cur_q;
            state_d = StWait;
         end
         default: state_d = StWait;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StWait;
         cur_q   <= LBUF_ID_1;
         id_q    <= 1'b0;
         addr_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         id_q    <= id_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
      end
   end

   assign eng_vld    = (state_q == StOffer);
   assign busy       = (state_q == StBusy);
   assign lbuf1_dn   = rel1;
   assign lbuf2_dn   = rel2;
   assign eng_addr   = addr_q;
   assign eng_id     = id_q;
   assign served_cnt = cnt_q;

endmodule
